// File: rtl/cpu_mem_loader.sv
`default_nettype none
// cpu_mem_loader: streams a program into IMEM and data into DMEM over the CPU's external
// ports, releases the CPU for a fixed cycle budget, then streams DMEM contents back out.
module cpu_mem_loader #(
   parameter int IMEM_WORDS = 128,
   parameter int DMEM_WORDS = 128,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic [7:0]       n_imem,
   input  logic [7:0]       n_dmem,
   input  logic [CNT_W-1:0] run_cycles,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             cpu_arst_n,
   output logic             cpu_enable,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   output logic [63:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [63:0]      wdata_ext_2,
   input  logic [63:0]      rdata_ext_2,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_I = 3'd1,
      S_LOAD_D = 3'd2,
      S_RUN    = 3'd3,
      S_DUMP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Depths above 255 can never be exceeded by an 8-bit count, so they saturate at 256.
   localparam logic [8:0] IMAX = (IMEM_WORDS > 255) ? 9'd256 : 9'(IMEM_WORDS);
   localparam logic [8:0] DMAX = (DMEM_WORDS > 255) ? 9'd256 : 9'(DMEM_WORDS);

   state_t           state_q, state_d;
   logic [7:0]       idx_q, idx_d;
   logic [7:0]       ni_q, ni_d;
   logic [7:0]       nd_q, nd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wen_i_q, wen_i_d;
   logic             wen_d_q, wen_d_d;
   logic             ren_q, ren_d;
   logic             rd_wait_q, rd_wait_d;
   logic [63:0]      addr_i_q, addr_i_d;
   logic [31:0]      wdata_i_q, wdata_i_d;
   logic [63:0]      addr_d_q, addr_d_d;
   logic [63:0]      wdata_d_q, wdata_d_d;
   logic             ov_q, ov_d;
   logic [63:0]      od_q, od_d;

   logic [7:0]       w_ni, w_nd;

   assign w_ni = ({1'b0, n_imem} > IMAX) ? IMAX[7:0] : n_imem;
   assign w_nd = ({1'b0, n_dmem} > DMAX) ? DMAX[7:0] : n_dmem;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ni_d      = ni_q;
      nd_d      = nd_q;
      cnt_d     = cnt_q;
      wen_i_d   = 1'b0;
      wen_d_d   = 1'b0;
      ren_d     = 1'b0;
      rd_wait_d = ren_q;
      addr_i_d  = addr_i_q;
      wdata_i_d = wdata_i_q;
      addr_d_d  = addr_d_q;
      wdata_d_d = wdata_d_q;
      ov_d      = ov_q;
      od_d      = od_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               ni_d  = w_ni;
               nd_d  = w_nd;
               cnt_d = run_cycles;
               idx_d = 8'd0;
               if (w_ni != 8'd0)               state_d = S_LOAD_I;
               else if (w_nd != 8'd0)          state_d = S_LOAD_D;
               else if (run_cycles != '0)      state_d = S_RUN;
               else                            state_d = S_DONE;
            end
         end
         S_LOAD_I: begin
            if (in_valid) begin
               wen_i_d   = 1'b1;
               addr_i_d  = {54'd0, idx_q, 2'b00};
               wdata_i_d = in_data[31:0];
               if (idx_q == ni_q - 8'd1) begin
                  idx_d = 8'd0;
                  if (nd_q != 8'd0)       state_d = S_LOAD_D;
                  else if (cnt_q != '0)   state_d = S_RUN;
                  else                    state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_LOAD_D: begin
            if (in_valid) begin
               wen_d_d   = 1'b1;
               addr_d_d  = {53'd0, idx_q, 3'b000};
               wdata_d_d = in_data;
               if (idx_q == nd_q - 8'd1) begin
                  idx_d   = 8'd0;
                  state_d = (cnt_q != '0) ? S_RUN : S_DUMP;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               idx_d   = 8'd0;
               state_d = (nd_q != 8'd0) ? S_DUMP : S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DUMP: begin
            // One read in flight at a time: issue only when nothing is pending or presented.
            if (rd_wait_q) begin
               od_d = rdata_ext_2;
               ov_d = 1'b1;
            end else if (ov_q) begin
               if (out_ready) begin
                  ov_d = 1'b0;
                  if (idx_q == nd_q - 8'd1) begin
                     idx_d   = 8'd0;
                     state_d = S_DONE;
                  end else begin
                     idx_d = idx_q + 8'd1;
                  end
               end
            end else if (!ren_q) begin
               ren_d    = 1'b1;
               addr_d_d = {53'd0, idx_q, 3'b000};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= S_IDLE;
         idx_q     <= 8'd0;
         ni_q      <= 8'd0;
         nd_q      <= 8'd0;
         cnt_q     <= '0;
         wen_i_q   <= 1'b0;
         wen_d_q   <= 1'b0;
         ren_q     <= 1'b0;
         rd_wait_q <= 1'b0;
         addr_i_q  <= 64'd0;
         wdata_i_q <= 32'd0;
         addr_d_q  <= 64'd0;
         wdata_d_q <= 64'd0;
         ov_q      <= 1'b0;
         od_q      <= 64'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ni_q      <= ni_d;
         nd_q      <= nd_d;
         cnt_q     <= cnt_d;
         wen_i_q   <= wen_i_d;
         wen_d_q   <= wen_d_d;
         ren_q     <= ren_d;
         rd_wait_q <= rd_wait_d;
         addr_i_q  <= addr_i_d;
         wdata_i_q <= wdata_i_d;
         addr_d_q  <= addr_d_d;
         wdata_d_q <= wdata_d_d;
         ov_q      <= ov_d;
         od_q      <= od_d;
      end
   end

   assign in_ready    = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
   assign busy        = in_ready || (state_q == S_RUN) || (state_q == S_DUMP);
   assign done        = (state_q == S_DONE);
   assign cpu_enable  = (state_q == S_RUN);
   assign cpu_arst_n  = (state_q == S_RUN) || (state_q == S_DUMP) || (state_q == S_DONE);
   assign out_valid   = ov_q;
   assign out_data    = od_q;
   assign addr_ext    = addr_i_q;
   assign wen_ext     = wen_i_q;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = wdata_i_q;
   assign addr_ext_2  = addr_d_q;
   assign wen_ext_2   = wen_d_q;
   assign ren_ext_2   = ren_q;
   assign wdata_ext_2 = wdata_d_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_loader.sv
`default_nettype none
// tb_cpu_mem_loader: directed jobs checked every cycle against a transaction-level model
// (expected write lists, expected dump list, expected run length).
module tb_cpu_mem_loader;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  n_imem = 8'd0;
   logic [7:0]  n_dmem = 8'd0;
   logic [31:0] run_cycles = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        cpu_arst_n, cpu_enable;
   logic [63:0] addr_ext;
   logic        wen_ext, ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2, ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic [63:0] rdata_ext_2 = 64'd0;
   logic        busy, done;

   cpu_mem_loader #(.IMEM_WORDS(128), .DMEM_WORDS(128), .CNT_W(32)) dut (
      .clk(clk), .arst(arst), .start(start), .n_imem(n_imem), .n_dmem(n_dmem),
      .run_cycles(run_cycles), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Memories the CPU would own; read data is garbage except the cycle after a read.
   logic [31:0] imem [0:127];
   logic [63:0] dmem [0:127];
   always @(posedge clk) begin
      if (wen_ext)   imem[addr_ext[8:2]] <= wdata_ext;
      if (wen_ext_2) dmem[addr_ext_2[9:3]] <= wdata_ext_2;
      rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[9:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   // Expectations posted by the driver for the current job.
   logic [31:0] exp_i [0:255];
   logic [63:0] exp_d [0:255];
   int          exp_ni = 0, exp_nd = 0;
   logic [31:0] exp_run = 32'd0;
   bit          hold_rst = 1'b0;
   int          pin_sel = 0;
   int          job_id = 0, end_req = 0, tmo = 0;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Compare process
   int          wi = 0, wd = 0, rd = 0, dmp = 0, en_len = 0, run_seen = 0;
   int          seen_job = 0, end_seen = 0, tmo_seen = 0;
   bit          prev_en = 0, prev_ov = 0, prev_ordy = 0, prev_ren = 0;
   logic [63:0] prev_od = 64'd0;

   always @(negedge clk) begin
      if (arst) begin
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_done", 64'(done), 64'd0);
         chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
         chk("rst_cpu_arst_n", 64'(cpu_arst_n), 64'd0);
         chk("rst_wen_ext", 64'(wen_ext), 64'd0);
         chk("rst_wen_ext_2", 64'(wen_ext_2), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         wi = 0; wd = 0; rd = 0; dmp = 0; en_len = 0; run_seen = 0;
         prev_en = 0; prev_ov = 0; prev_ordy = 0; prev_ren = 0;
      end else begin
         if (job_id != seen_job) begin
            wi = 0; wd = 0; rd = 0; dmp = 0; en_len = 0; run_seen = 0;
            seen_job = job_id;
         end
         chk("ren_ext_zero", 64'(ren_ext), 64'd0);
         if (wen_ext) begin
            chk("imem_addr", addr_ext, 64'(4 * wi));
            chk("imem_data", 64'(wdata_ext), 64'(exp_i[wi]));
            chk("wen_exclusive", 64'(wen_ext_2), 64'd0);
            wi++;
         end
         if (wen_ext_2) begin
            chk("dmem_addr", addr_ext_2, 64'(8 * wd));
            chk("dmem_data", wdata_ext_2, exp_d[wd]);
            chk("ren_wen_exclusive", 64'(ren_ext_2), 64'd0);
            wd++;
         end
         if (ren_ext_2) begin
            chk("read_addr", addr_ext_2, 64'(8 * rd));
            chk("read_while_valid", 64'(out_valid), 64'd0);
            chk("read_single_cycle", 64'(prev_ren), 64'd0);
            rd++;
         end
         if (prev_ov && !prev_ordy) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, prev_od);
         end
         if (out_valid && out_ready) begin
            chk("dump_data", out_data, exp_d[dmp]);
            dmp++;
         end
         if (in_ready) chk("load_cpu_in_reset", 64'(cpu_arst_n), 64'd0);
         if (hold_rst && !done) chk("early_release", 64'(cpu_arst_n), 64'd0);
         if (cpu_enable) begin
            chk("run_arst_n", 64'(cpu_arst_n), 64'd1);
            en_len++;
         end else if (prev_en) begin
            chk("run_len", 64'(en_len), 64'(exp_run));
            run_seen++;
            en_len = 0;
         end
         prev_en   = cpu_enable;
         prev_ov   = out_valid;
         prev_ordy = out_ready;
         prev_od   = out_data;
         prev_ren  = ren_ext_2;
         if (end_req != end_seen) begin
            end_seen = end_req;
            chk("job_imem_writes", 64'(wi), 64'(exp_ni));
            chk("job_dmem_writes", 64'(wd), 64'(exp_nd));
            chk("job_dump_words", 64'(dmp), 64'(exp_nd));
            chk("job_runs", 64'(run_seen), (exp_run != 0) ? 64'd1 : 64'd0);
            chk("job_done", 64'(done), 64'd1);
            chk("job_busy", 64'(busy), 64'd0);
            chk("job_cpu_released", 64'(cpu_arst_n), 64'd1);
            chk("job_out_valid", 64'(out_valid), 64'd0);
            if (pin_sel == 1) begin
               chk("pin_imem0", 64'(imem[0]), 64'h0000_0000_0000_0013);
               chk("pin_imem1", 64'(imem[1]), 64'h0000_0000_0010_0093);
               chk("pin_imem2", 64'(imem[2]), 64'h0000_0000_0020_8113);
               chk("pin_imem_count", 64'(wi), 64'd3);
            end else if (pin_sel == 2) begin
               chk("pin_dmem0", dmem[0], 64'hAAAA_AAAA_AAAA_AAAA);
               chk("pin_dmem1", dmem[1], 64'h5555_5555_5555_5555);
               chk("pin_dump_count", 64'(dmp), 64'd2);
            end else if (pin_sel == 3) begin
               chk("pin_clamp_count", 64'(wi), 64'd128);
               chk("pin_clamp_last", 64'(imem[127]), 64'h0000_0000_1000_007F);
            end
         end
         if (tmo != tmo_seen) begin
            chk("timeout", 64'(tmo), 64'(tmo_seen));
            tmo_seen = tmo;
         end
      end
   end

   // Driver (all drives happen 1 time unit after a rising edge)
   task automatic pulse_rst();
      arst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      arst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic feed(input logic [63:0] d, input bit gap);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) tmo++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap) begin
         in_data = 64'hFFFF_FFFF_FFFF_FFFF;
         @(posedge clk); #1;
      end
   endtask

   // mode: 0 normal, 1 reset after two DMEM words, 2 reset mid-RUN, 3 stray start during RUN
   task automatic job(input int ni, input int nd, input logic [31:0] rc, input bit gap,
                      input int stall, input int mode, input int pin);
      int eni, ednd, t, sl, ec;
      eni  = (ni > 128) ? 128 : ni;
      ednd = (nd > 128) ? 128 : nd;
      exp_ni = eni; exp_nd = ednd; exp_run = rc; pin_sel = pin;
      hold_rst = (ednd == 0 && rc == 0);
      n_imem = 8'(ni); n_dmem = 8'(nd); run_cycles = rc;
      start = 1'b1;
      job_id++;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < eni; k++) feed({32'd0, exp_i[k]}, 1'b0);
      for (int k = 0; k < ednd; k++) begin
         if (mode == 1 && k == 2) begin
            pulse_rst();
            return;
         end
         feed(exp_d[k], gap);
      end
      sl = stall; ec = 0; t = 0;
      while (!done && t < 3000) begin
         if (out_valid && sl > 0) begin
            out_ready = 1'b0;
            sl--;
         end else begin
            out_ready = 1'b1;
         end
         if (cpu_enable) ec++;
         if (mode == 2 && ec == 5) begin
            pulse_rst();
            return;
         end
         if (mode == 3 && ec == 3 && cpu_enable) begin
            start = 1'b1; n_imem = 8'd7; n_dmem = 8'd7; run_cycles = 32'd99;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         t++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (t >= 3000) tmo++;
      else begin
         @(posedge clk); #1;
         end_req++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      arst = 1'b0;
      @(posedge clk); #1;

      // Program load only; CPU must stay in reset until DONE.
      exp_i[0] = 32'h0000_0013; exp_i[1] = 32'h0010_0093; exp_i[2] = 32'h0020_8113;
      job(3, 0, 32'd0, 1'b0, 0, 0, 1);

      // Data load and dump round trip.
      exp_d[0] = 64'hAAAA_AAAA_AAAA_AAAA; exp_d[1] = 64'h5555_5555_5555_5555;
      job(0, 2, 32'd0, 1'b0, 0, 0, 2);

      // Run only, with a start pulse during RUN that must be ignored.
      job(0, 0, 32'd10, 1'b0, 0, 3, 0);

      // Full flow with dump back-pressure.
      exp_i[0] = 32'hDEAD_BEEF; exp_i[1] = 32'h1234_5678;
      for (int k = 0; k < 3; k++) exp_d[k] = {32'hD000_0000 + 32'(k), 32'hC0DE_0000 + 32'(k)};
      job(2, 3, 32'd4, 1'b0, 5, 0, 0);

      // in_valid toggling every other cycle during LOAD_D.
      for (int k = 0; k < 4; k++) exp_d[k] = {32'h0BAD_F00D, 32'(k * 3 + 1)};
      job(0, 4, 32'd0, 1'b1, 0, 0, 0);

      // Reset mid-LOAD_D, then mid-RUN.
      job(0, 4, 32'd0, 1'b0, 0, 1, 0);
      job(0, 0, 32'd50, 1'b0, 0, 2, 0);

      // Recovery after reset.
      exp_i[0] = 32'h0000_006F;
      exp_d[0] = 64'h0123_4567_89AB_CDEF;
      job(1, 1, 32'd3, 1'b0, 0, 0, 0);

      // Oversized IMEM count clamps to depth.
      for (int k = 0; k < 128; k++) exp_i[k] = 32'h1000_0000 + 32'(k);
      job(200, 0, 32'd0, 1'b0, 0, 0, 3);

      @(negedge clk);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
